// File: rtl/dcm_ps_responder_if.sv
// dcm_ps_responder_if: phase-shift request/response and delay-line signals between a controller side and the responder.
interface dcm_ps_if;
    logic       psen_i;
    logic       psincdec_i;
    logic       psdone_o;
    logic [7:0] status_o;
    logic [8:0] phase_o;
    logic       locked_i;
    logic       clk_stopped_i;
    logic       dly_ce_o;
    logic       dly_inc_o;
    logic       dly_busy_i;
    modport master (
        output psen_i, psincdec_i, locked_i, clk_stopped_i, dly_busy_i,
        input  psdone_o, status_o, phase_o, dly_ce_o, dly_inc_o
    );
    modport slave (
        input  psen_i, psincdec_i, locked_i, clk_stopped_i, dly_busy_i,
        output psdone_o, status_o, phase_o, dly_ce_o, dly_inc_o
    );
endinterface

// File: rtl/dcm_ps_responder.sv
// dcm_ps_responder: DCM-style phase-shift target that steps a fine delay line and tracks the signed phase.
module dcm_ps_responder #(
    parameter int PS_MAX     = 255,
    parameter int PS_LATENCY = 4
) (
    input logic     clk_i,
    input logic     reset_i,
    dcm_ps_if.slave ps
);
    localparam int CW = (PS_LATENCY > 1) ? $clog2(PS_LATENCY) : 1;
    localparam logic signed [8:0] PMAX = 9'(PS_MAX);
    localparam logic signed [8:0] NMAX = -PMAX;
    localparam logic [CW-1:0] CLAST = CW'(PS_LATENCY - 1);
    typedef enum logic [2:0] {IDLE, STEP, WAIT_BUSY, DELAY, DONE} state_t;
    state_t state, state_n;
    logic dir, dir_n, ovf, ovf_n;
    logic signed [8:0] phase, phase_n;
    logic [CW-1:0] cnt, cnt_n;
    always_comb begin
        state_n = state;
        dir_n   = dir;
        ovf_n   = ovf;
        phase_n = phase;
        cnt_n   = cnt;
        case (state)
            IDLE: if (ps.psen_i && ps.locked_i) begin
                dir_n = ps.psincdec_i;
                cnt_n = '0;
                if (ps.psincdec_i ? (phase < PMAX) : (phase > NMAX)) begin
                    state_n = STEP;
                end else begin
                    state_n = DELAY;
                    ovf_n   = 1'b1;
                end
            end
            STEP: begin
                phase_n = dir ? phase + 9'sd1 : phase - 9'sd1;
                ovf_n   = 1'b0;
                state_n = WAIT_BUSY;
            end
            WAIT_BUSY: state_n = ps.dly_busy_i ? WAIT_BUSY : DELAY;
            DELAY: begin
                cnt_n   = cnt + 1'b1;
                state_n = (cnt == CLAST) ? DONE : DELAY;
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    // Pulses are registered from the next state so they line up with the state they announce.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state        <= IDLE;
            dir          <= 1'b0;
            ovf          <= 1'b0;
            phase        <= '0;
            cnt          <= '0;
            ps.dly_ce_o  <= 1'b0;
            ps.dly_inc_o <= 1'b0;
            ps.psdone_o  <= 1'b0;
        end else begin
            state        <= state_n;
            dir          <= dir_n;
            ovf          <= ovf_n;
            phase        <= phase_n;
            cnt          <= cnt_n;
            ps.dly_ce_o  <= state_n == STEP;
            ps.dly_inc_o <= (state_n == STEP) ? dir_n : ps.dly_inc_o;
            ps.psdone_o  <= state_n == DONE;
        end
    end
    assign ps.phase_o  = phase;
    assign ps.status_o = {5'b0, ps.clk_stopped_i, 1'b0, ovf};
endmodule
